// File: rtl/mul4_eval_pkg.sv
// mul4_eval_pkg: shared FSM encoding and constants for the multiplier fitness evaluator
package mul4_eval_pkg;
  typedef enum logic [2:0] {IDLE, GEN, MUL, CMP, FIN} state_t;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;
  localparam int MUL_ITER = 32;
endpackage

// File: rtl/mul32_seq.sv
// mul32_seq: 32x32 unsigned shift-add multiplier, one partial product per cycle
module mul32_seq
  import mul4_eval_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product,
  output logic        valid
);
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;
  assign valid = cnt == 6'(MUL_ITER);
  // The loading edge already folds in bit 0, so the last bit lands one edge before the FSM leaves MUL
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      product <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (start) begin
      product <= b[0] ? {32'h0, a} : 64'h0;
      mcand <= {31'h0, a, 1'b0};
      mplier <= {1'b0, b[31:1]};
      cnt <= 6'd1;
    end else if (cnt != 6'd0 && !valid) begin
      product <= product + (mplier[0] ? mcand : 64'h0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 6'd1;
    end
endmodule

// File: rtl/mul4_fitness_eval.sv
// mul4_fitness_eval: drives operand vectors into a candidate multiplier and accumulates
// the bit-error count of its result against an exact iterative multiplier.
module mul4_fitness_eval
  import mul4_eval_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = DEFAULT_SEED,
  parameter int          SCORE_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        num_vectors,
  input  logic               vec_mode,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score
);
  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  state_t state, state_n;
  logic [31:0] lfsr, lfsr_1, a_n, b_n, a_q, b_q;
  logic [15:0] n_vec, cnt, cnt_inc;
  logic        mode, mul_valid;
  logic [63:0] product, err;
  logic [6:0]  pc;
  logic [SCORE_W:0] sum;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
  assign lfsr_1 = lfsr_step(lfsr);
  assign a_n = mode ? op_a : lfsr;
  assign b_n = mode ? op_b : lfsr_1;
  assign {a1, a0} = a_q;
  assign {b1, b0} = b_q;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign cnt_inc = cnt + 16'd1;
  assign err = product ^ {y3, y2, y1, y0};
  assign sum = {1'b0, score} + {{(SCORE_W-6){1'b0}}, pc};
  always_comb begin
    pc = '0;
    for (int i = 0; i < 64; i++) pc = pc + {6'b0, err[i]};
  end
  mul32_seq u_mul (
    .clk(clk), .rst(rst), .start(state == GEN), .a(a_n), .b(b_n),
    .product(product), .valid(mul_valid)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (num_vectors == 16'd0) ? FIN : GEN;
      GEN:  state_n = MUL;
      MUL:  if (mul_valid) state_n = CMP;
      CMP:  state_n = (cnt_inc == n_vec) ? FIN : GEN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr <= SEED;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      n_vec <= '0;
      mode <= 1'b0;
      score <= '0;
    end else begin
      if (state == IDLE && start) begin
        lfsr <= SEED;
        cnt <= '0;
        score <= '0;
        n_vec <= num_vectors;
        mode <= vec_mode;
      end
      if (state == GEN) begin
        a_q <= a_n;
        b_q <= b_n;
        lfsr <= lfsr_step(lfsr_1);
      end
      if (state == CMP) begin
        cnt <= cnt_inc;
        score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      end
    end
endmodule

// File: doc/mul4_fitness_eval.md
MUL4_FITNESS_EVAL -- requirements
Module: mul4_fitness_eval

Interface
REQ-001 Parameter: LFSR_SEED, 32'hACE1_2468, reset/restart seed of the operand LFSR; a zero value SHALL be replaced by 32'h0000_0001.
REQ-002 Parameter: SCORE_W, 24, width of the error-score accumulator.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin an evaluation run.
REQ-006 Port: num_vectors  input  16  vectors per run, sampled on accepted start.
REQ-007 Port: vec_mode  input  1  0 = LFSR operands, 1 = operands from op_a/op_b; sampled on accepted start.
REQ-008 Port: op_a, op_b  input  32 each  directed operands used when vec_mode=1.
REQ-009 Port: a1, a0, b1, b0  output  16 each  operand words driven to the combinational candidate; a={a1,a0}, b={b1,b0}.
REQ-010 Port: y3, y2, y1, y0  input  16 each  candidate result; {y3,y2,y1,y0} is compared against a*b.
REQ-011 Port: busy  output  1  high while a run is in progress.
REQ-012 Port: done  output  1  one-cycle pulse at end of run.
REQ-013 Port: score  output  SCORE_W  accumulated bit-error count, held until the next accepted start.

Function
REQ-014 FSM states SHALL be IDLE, GEN, MUL, CMP, FIN.
REQ-015 IDLE: start=1 SHALL be accepted, clear score and the vector counter, reload the LFSR from the seed, and go to FIN if num_vectors=0 or to GEN otherwise.
REQ-016 GEN (1 cycle): the block SHALL register operands (LFSR: a = current state, b = state after one advance, LFSR advanced twice; vec_mode=1: a=op_a, b=op_b), drive them onto a1..b0, and start the multiplier.
REQ-017 MUL: the block SHALL hold operands stable while the 32-iteration shift-add multiplier runs, one iteration per cycle (32 cycles), then go to CMP.
REQ-018 CMP (1 cycle): the block SHALL sample y3..y0, add popcount(golden ^ {y3,y2,y1,y0}) (0..64) to score, and increment the counter; if counter = num_vectors it SHALL go to FIN, otherwise to GEN.
REQ-019 Per-vector latency SHALL be exactly 34 cycles (GEN + 32 MUL + CMP); run length SHALL be 34*N+1 cycles from start to done.
REQ-020 FIN: done=1 for one cycle, then the FSM SHALL return to IDLE; busy SHALL be 1 in GEN, MUL, CMP, and FIN.
REQ-021 score SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 Golden product SHALL be full 64-bit unsigned a*b with no truncation.
REQ-024 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1; it SHALL advance only in GEN.
REQ-025 Operand outputs SHALL retain the last values after the run ends.

Reset
REQ-026 Asynchronous assertion of rst SHALL force: state=IDLE, busy=0, done=0, score=0, a1=a0=b1=b0=0, counter=0, LFSR=LFSR_SEED (or 1 when the seed is zero), and multiplier registers 0.
REQ-027 rst asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL accept start on the first clock.

Structure
REQ-028 Shared package mul4_eval_pkg SHALL hold the FSM state enum, LFSR polynomial constant, default seed, and MUL_ITER=32.
REQ-029 Sub-module mul32_seq (start, a, b -> product[63:0], valid) SHALL implement the iterative multiplier; popcount and LFSR stay inline.

Verification
REQ-030 Bench SHALL cover: vec_mode=1, op_a=3, op_b=5, candidate tied to 0, N=1 -> done at cycle 35 after start, score=4.
REQ-031 Bench SHALL cover: vec_mode=1, op_a=op_b=32'hFFFF_FFFF, candidate = exact multiplier model, N=10 -> score=0.
REQ-032 Bench SHALL cover: vec_mode=1, op_a=op_b=32'hFFFF_FFFF, candidate tied to all-ones, N=2 -> golden=64'hFFFF_FFFE_0000_0001, score=2*32=64.
REQ-033 Bench SHALL cover: N=0 -> done pulse on the cycle after start, score=0, busy=1 for exactly 1 cycle.
REQ-034 Bench SHALL cover: LFSR mode, N=100, exact candidate, start re-pulsed mid-run -> ignored, score=0, done after 3401 cycles.
REQ-035 Bench SHALL cover: rst pulsed during MUL of vector 3 -> all outputs at reset values, no done pulse; a new run then matches a clean run bit-for-bit.
